// File: rtl/ysyx_22040386_mem_arb.sv
// Two-requester (IFU / LSU) arbiter and sequencer for the shared memory port, with timeout error responses.
// Optional YSYX_22040386_ARB_RR_EN selects round-robin arbitration; default is fixed LSU priority.
module ysyx_22040386_mem_arb #(
  parameter int TIMEOUT = 1023
) (
  input  logic        i_ARB_clk,
  input  logic        i_ARB_rst,
  input  logic        i_ARB_if_req,
  input  logic [63:0] i_ARB_if_addr,
  output logic        o_ARB_if_gnt,
  output logic        o_ARB_if_rvalid,
  output logic [63:0] o_ARB_if_rdata,
  output logic        o_ARB_if_err,
  input  logic        i_ARB_ls_req,
  input  logic        i_ARB_ls_we,
  input  logic [63:0] i_ARB_ls_addr,
  input  logic [63:0] i_ARB_ls_wdata,
  input  logic [7:0]  i_ARB_ls_wmask,
  output logic        o_ARB_ls_gnt,
  output logic        o_ARB_ls_rvalid,
  output logic [63:0] o_ARB_ls_rdata,
  output logic        o_ARB_ls_err,
  output logic        o_ARB_mem_req,
  output logic        o_ARB_mem_we,
  output logic [63:0] o_ARB_mem_addr,
  output logic [63:0] o_ARB_mem_wdata,
  output logic [7:0]  o_ARB_mem_wmask,
  input  logic        i_ARB_mem_ack,
  input  logic        i_ARB_mem_rvalid,
  input  logic [63:0] i_ARB_mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state;
  logic          owner_ls;
  logic          we_q;
  logic [63:0]   addr_q;
  logic [63:0]   wdata_q;
  logic [7:0]    wmask_q;
  logic [63:0]   rdata_q;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          gnt_if;
  logic          gnt_ls;

`ifdef YSYX_22040386_ARB_RR_EN
  logic last_ls;

  // On a conflict the side not granted last wins; pointer starts at IF so LSU wins first.
  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (state == S_IDLE) begin
      if (i_ARB_if_req && i_ARB_ls_req) begin
        gnt_ls = ~last_ls;
        gnt_if = last_ls;
      end else begin
        gnt_ls = i_ARB_ls_req;
        gnt_if = i_ARB_if_req;
      end
    end
  end

  always_ff @(posedge i_ARB_clk) begin
    if (i_ARB_rst)
      last_ls <= 1'b0;
    else if (gnt_if || gnt_ls)
      last_ls <= gnt_ls;
  end
`else
  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (state == S_IDLE) begin
      gnt_ls = i_ARB_ls_req;
      gnt_if = i_ARB_if_req & ~i_ARB_ls_req;
    end
  end
`endif

  always_ff @(posedge i_ARB_clk) begin
    if (i_ARB_rst) begin
      state    <= S_IDLE;
      owner_ls <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      wmask_q  <= 8'd0;
      rdata_q  <= 64'd0;
      err_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_if || gnt_ls) begin
            owner_ls <= gnt_ls;
            we_q     <= gnt_ls & i_ARB_ls_we;
            addr_q   <= gnt_ls ? i_ARB_ls_addr : i_ARB_if_addr;
            wdata_q  <= gnt_ls ? i_ARB_ls_wdata : 64'd0;
            wmask_q  <= (gnt_ls && i_ARB_ls_we) ? i_ARB_ls_wmask : 8'd0;
            err_q    <= 1'b0;
            cnt      <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          cnt <= cnt + CW'(1);
          // A response in ISSUE only counts together with the ack that accepts the request.
          if (i_ARB_mem_rvalid && (state == S_WAIT || i_ARB_mem_ack)) begin
            rdata_q <= i_ARB_mem_rdata;
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (cnt == TMO) begin
            rdata_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end else if (state == S_ISSUE && i_ARB_mem_ack) begin
            state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_ARB_if_gnt    = gnt_if;
  assign o_ARB_ls_gnt    = gnt_ls;
  assign o_ARB_if_rvalid = (state == S_RESP) & ~owner_ls;
  assign o_ARB_ls_rvalid = (state == S_RESP) & owner_ls;
  assign o_ARB_if_rdata  = rdata_q;
  assign o_ARB_ls_rdata  = rdata_q;
  assign o_ARB_if_err    = o_ARB_if_rvalid & err_q;
  assign o_ARB_ls_err    = o_ARB_ls_rvalid & err_q;
  assign o_ARB_mem_req   = (state == S_ISSUE);
  assign o_ARB_mem_we    = we_q;
  assign o_ARB_mem_addr  = addr_q;
  assign o_ARB_mem_wdata = wdata_q;
  assign o_ARB_mem_wmask = wmask_q;

endmodule
